pool1_max_sender: RTL and testbench

Transmit side of the pool-1 pixel handshake. Accepts the conv-1 output stream (one 16-channel pixel per beat, row-major), performs 2x2 stride-2 signed max-pooling per channel, queues pooled pixels, and presents each one to the pool-1 line buffer with a single-cycle `start` pulse and a stable data hold window. It sits between the conv-1 array and the pool-1 output buffer.

---
 rtl/pool1_max_sender_pkg.sv | 60 ++++++
 rtl/pool1_sender_fifo.sv | 59 +++++
 rtl/pool1_max_sender.sv | 208 ++++++++++++++++++++
 tb/tb_pool1_max_sender.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool1_max_sender_pkg.sv
// Shared definitions for the pool-1 max-pooling sender: bus geometry,
// frame geometry, FIFO sizing, TX handshake timing, FSM states and
// per-lane signed max / clamp helpers.
package pool1_max_sender_pkg;

    localparam int BITS         = 16;
    localparam int BITS_SHIFT   = 4;
    localparam int CHANNEL_NUM  = 16;
    localparam int BUS_W        = CHANNEL_NUM << BITS_SHIFT;
    localparam int IN_LENGTH    = 58;
    localparam int IN_HEIGHT    = 58;
    localparam int CNT_BITS     = 6;
    localparam int FIFO_DEPTH   = 8;
    localparam int FIFO_DEPTH_2 = 3;
    localparam int FCNT_W       = FIFO_DEPTH_2 + 1;
    localparam int HOLD_CYCLES  = 4;
    localparam int PULSE_PERIOD = 6;
    localparam int GAP_CYCLES   = PULSE_PERIOD - 1 - HOLD_CYCLES;
    localparam int TIMER_BITS   = 3;
    localparam int ROW_STORE_N  = IN_LENGTH / 2;
    localparam int PIX_PER_FRAME = (IN_LENGTH / 2) * (IN_HEIGHT / 2);
    localparam int SENT_BITS    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Per-lane two's-complement maximum of two pixels.
    function automatic logic [BUS_W-1:0] lane_max(input logic [BUS_W-1:0] a,
                                                  input logic [BUS_W-1:0] b);
        logic [BUS_W-1:0] res;
        res = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if ($signed(a[k*BITS +: BITS]) > $signed(b[k*BITS +: BITS])) begin
                res[k*BITS +: BITS] = a[k*BITS +: BITS];
            end else begin
                res[k*BITS +: BITS] = b[k*BITS +: BITS];
            end
        end
        return res;
    endfunction

    // Per-lane clamp of negative values to zero.
    function automatic logic [BUS_W-1:0] lane_relu(input logic [BUS_W-1:0] a);
        logic [BUS_W-1:0] res;
        res = a;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if (a[k*BITS + BITS - 1]) begin
                res[k*BITS +: BITS] = '0;
            end else begin
                res[k*BITS +: BITS] = a[k*BITS +: BITS];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pool1_sender_fifo.sv
// Synchronous first-word-fall-through FIFO for pooled pixels.
// Writes to a full FIFO and reads from an empty FIFO are ignored.
module pool1_sender_fifo
    import pool1_max_sender_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [BUS_W-1:0]  i_wdata,
    input  logic              i_pop,
    output logic [BUS_W-1:0]  o_rdata,
    output logic [FCNT_W-1:0] o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [BUS_W-1:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_2-1:0] r_rd_ptr;
    logic [FCNT_W-1:0]       r_count;
    logic                    w_do_push;
    logic                    w_do_pop;

    assign o_empty   = (r_count == FCNT_W'(0));
    assign o_full    = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_2'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_2'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pool1_max_sender.sv
// Pool-1 transmit side: 2x2 stride-2 signed max-pooling of the conv-1
// stream, pooled-pixel queue, and start/hold/gap handshake to the line
// buffer. Optional feature macro: POOL1_SENDER_RELU_EN clamps negative
// pooled lanes to zero before they are queued.
module pool1_max_sender
    import pool1_max_sender_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [BUS_W-1:0] data_out,
    output logic             start,
    output logic             frame_done
);

    logic [CNT_BITS-1:0]   r_col;
    logic [CNT_BITS-1:0]   r_row;
    logic [BUS_W-1:0]      r_left;
    logic [BUS_W-1:0]      r_row_store [ROW_STORE_N];
    logic [BUS_W-1:0]      r_pool_data;
    logic                  r_pool_valid;
    logic                  r_din_ready;
    tx_state_e             r_state;
    logic [TIMER_BITS-1:0] r_timer;
    logic [SENT_BITS-1:0]  r_sent;
    logic [BUS_W-1:0]      r_data_out;
    logic                  r_start;
    logic                  r_frame_done;

    logic                  w_accept;
    logic [CNT_BITS-2:0]   w_half_col;
    logic [BUS_W-1:0]      w_hmax;
    logic [BUS_W-1:0]      w_pooled;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load_slot;
    logic [BUS_W-1:0]      w_fifo_rdata;
    logic [FCNT_W-1:0]     w_fifo_count;
    logic [FCNT_W-1:0]     w_count_next;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign w_accept   = din_valid & r_din_ready;
    assign w_half_col = r_col[CNT_BITS-1:1];
    assign w_push     = r_pool_valid & ~w_fifo_full;
    // A pixel may be launched from IDLE or straight out of the last GAP
    // cycle, which keeps the start-to-start spacing at exactly PULSE_PERIOD.
    assign w_load_slot = (r_state == ST_IDLE) ||
                         ((r_state == ST_GAP) && (r_timer == TIMER_BITS'(0)));
    assign w_pop      = w_load_slot & ~w_fifo_empty;

    assign din_ready  = r_din_ready;
    assign data_out   = r_data_out;
    assign start      = r_start;
    assign frame_done = r_frame_done;

    // Horizontal and vertical lane maxima for the current beat.
    always_comb begin
        w_hmax   = lane_max(r_left, din);
`ifdef POOL1_SENDER_RELU_EN
        w_pooled = lane_relu(lane_max(w_hmax, r_row_store[w_half_col]));
`else
        w_pooled = lane_max(w_hmax, r_row_store[w_half_col]);
`endif
    end

    // Raster position of the next accepted beat.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == CNT_BITS'(IN_LENGTH - 1)) begin
                r_col <= '0;
                if (r_row == CNT_BITS'(IN_HEIGHT - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + CNT_BITS'(1);
                end
            end else begin
                r_col <= r_col + CNT_BITS'(1);
            end
        end
    end

    // Left half of the horizontal pair, captured on even columns.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_left <= '0;
        end else if (w_accept && !r_col[0]) begin
            r_left <= din;
        end
    end

    // Top-row horizontal maxima, one per output column; always rewritten
    // in an even row before the odd row reads them, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (w_accept && r_col[0] && !r_row[0]) begin
            r_row_store[w_half_col] <= w_hmax;
        end
    end

    // Registered pooled result, pushed into the queue the following cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
        end else begin
            r_pool_valid <= w_accept & r_col[0] & r_row[0];
            if (w_accept && r_col[0] && r_row[0]) begin
                r_pool_data <= w_pooled;
            end
        end
    end

    // Next-cycle queue occupancy, used to pre-compute the ready flag.
    always_comb begin
        w_count_next = w_fifo_count;
        if (w_push && !w_pop) begin
            w_count_next = w_fifo_count + FCNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = w_fifo_count - FCNT_W'(1);
        end else begin
            w_count_next = w_fifo_count;
        end
    end

    // Input ready: one queue slot stays free for the in-flight pooled result.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_din_ready <= 1'b0;
        end else begin
            r_din_ready <= (w_count_next < FCNT_W'(FIFO_DEPTH - 1));
        end
    end

    pool1_sender_fifo u_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (r_pool_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // TX handshake FSM with registered start/data/frame_done outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_sent       <= '0;
            r_data_out   <= '0;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_LOAD;
                        r_data_out <= w_fifo_rdata;
                        r_start    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_HOLD;
                    r_timer <= TIMER_BITS'(HOLD_CYCLES - 1);
                    r_sent  <= r_sent + SENT_BITS'(1);
                end
                ST_HOLD: begin
                    if (r_timer == TIMER_BITS'(0)) begin
                        r_state <= ST_GAP;
                        r_timer <= TIMER_BITS'(GAP_CYCLES - 1);
                        if (r_sent == SENT_BITS'(PIX_PER_FRAME)) begin
                            r_frame_done <= 1'b1;
                            r_sent       <= '0;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_BITS'(1);
                    end
                end
                ST_GAP: begin
                    if (r_timer == TIMER_BITS'(0)) begin
                        if (w_pop) begin
                            r_state    <= ST_LOAD;
                            r_data_out <= w_fifo_rdata;
                            r_start    <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_BITS'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool1_max_sender.sv
// Self-checking bench for pool1_max_sender. Expected pooled pixels come
// from an image array and a plain max-over-window model; honours the
// POOL1_SENDER_RELU_EN macro for expected values.
module tb_pool1_max_sender;

    localparam int W      = 256;
    localparam int L      = 58;
    localparam int H      = 58;
    localparam int NPIX   = (L / 2) * (H / 2);
    localparam int HOLD   = 4;
    localparam int PERIOD = 6;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] data_out;
    logic         start;
    logic         frame_done;

    pool1_max_sender dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .data_out   (data_out),
        .start      (start),
        .frame_done (frame_done)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [W-1:0] img [0:H-1][0:L-1];
    logic         cur_is_pool = 1'b0;
    int           last_accept_cyc = 0;

    // observations collected by the monitor
    logic [W-1:0] got_q [$];
    int           start_cyc_q [$];
    int           hold_viol, spacing_viol, min_spacing, fd_count, fd_last_cyc;
    int           rdy_viol, rdy_low_seen, win_acc;
    logic [W-1:0] prev_data;

    initial begin
        forever begin
            @(posedge clk_in);
            cyc = cyc + 1;
        end
    end

    // Output monitor, sampling on the falling edge.
    initial begin
        int sp;
        int outstanding;
        forever begin
            @(negedge clk_in);
            if (rst_n !== 1'b1) begin
                got_q.delete();
                start_cyc_q.delete();
                hold_viol = 0; spacing_viol = 0; min_spacing = 1000000;
                fd_count = 0; fd_last_cyc = -1; rdy_viol = 0; rdy_low_seen = 0;
                win_acc = 0; prev_data = '0;
            end else begin
                if (start === 1'b1) begin
                    if (start_cyc_q.size() > 0) begin
                        sp = cyc - start_cyc_q[$];
                        if (sp < PERIOD) spacing_viol++;
                        if (sp < min_spacing) min_spacing = sp;
                    end
                    got_q.push_back(data_out);
                    start_cyc_q.push_back(cyc);
                end else if (data_out !== prev_data) begin
                    hold_viol++;
                end
                prev_data = data_out;
                if (frame_done === 1'b1) begin
                    fd_count++;
                    fd_last_cyc = cyc;
                end
                // pooled windows accepted but not yet started = queue + in-flight
                outstanding = win_acc - got_q.size();
                if (din_ready === 1'b0) begin
                    rdy_low_seen++;
                    if (outstanding < 7) rdy_viol++;
                end else if (outstanding > 7) begin
                    rdy_viol++;
                end
                if (din_valid && din_ready === 1'b1 && cur_is_pool) win_acc++;
            end
        end
    end

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: per channel, the largest signed value in the 2x2 window.
    function automatic logic [W-1:0] ref_pool(input int pr, input int pc);
        logic [W-1:0]        res;
        logic [W-1:0]        px;
        logic signed [15:0]  v;
        int                  best;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            best = -1000000;
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    px = img[2*pr+dr][2*pc+dc];
                    v  = px[k*16 +: 16];
                    if (int'(v) > best) best = int'(v);
                end
            end
`ifdef POOL1_SENDER_RELU_EN
            if (best < 0) best = 0;
`endif
            res[k*16 +: 16] = best[15:0];
        end
        return res;
    endfunction

    task automatic send_beat(input int r, input int c, input int gap_max);
        int g;
        int budget;
        if (gap_max > 0) begin
            g = $urandom_range(gap_max, 0);
            if (g > 0) begin
                din_valid = 1'b0;
                repeat (g) @(posedge clk_in);
                #1;
            end
        end
        din         = img[r][c];
        din_valid   = 1'b1;
        cur_is_pool = (r % 2 == 1) && (c % 2 == 1);
        budget = 0;
        @(negedge clk_in);
        while (din_ready !== 1'b1 && budget < 2000) begin
            @(negedge clk_in);
            budget++;
        end
        if (din_ready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL beat_accept_timeout: row %0d col %0d ready %b, required 1", r, c, din_ready);
        end
        @(posedge clk_in);
        #1;
        last_accept_cyc = cyc;
        din_valid   = 1'b0;
        cur_is_pool = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        if (got_q.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: starts seen %0d, required %0d", nm, got_q.size(), n);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        din_valid = 1'b0;
        cur_is_pool = 1'b0;
        repeat (3) @(negedge clk_in);
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    // Feeds the first 2x2 window of a fresh frame and checks the single pooled pixel.
    task automatic run_window(input logic [W-1:0] p00, input logic [W-1:0] p01,
                              input logic [W-1:0] p10, input logic [W-1:0] p11,
                              input logic [W-1:0] cmask, input logic [W-1:0] cexp,
                              input string nm);
        logic [W-1:0] exp_px;
        int           acc;
        int           first_start;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < L; c++) img[r][c] = rand256();
        img[0][0] = p00; img[0][1] = p01; img[1][0] = p10; img[1][1] = p11;
        exp_px = ref_pool(0, 0);
        for (int c = 0; c < L; c++) send_beat(0, c, 0);
        send_beat(1, 0, 0);
        send_beat(1, 1, 0);
        acc = last_accept_cyc;
        wait_starts(1, 50, nm);
        repeat (12) @(negedge clk_in);
        first_start = (start_cyc_q.size() > 0) ? start_cyc_q[0] : -1;
        n_tests++;
        if (got_q.size() !== 1) begin
            n_fail++; $display("FAIL %s_start_count: got %0d, required 1", nm, got_q.size());
        end
        n_tests++;
        if (data_out !== exp_px) begin
            n_fail++; $display("FAIL %s_data: got %h, required %h", nm, data_out, exp_px);
        end
        n_tests++;
        if ((data_out & cmask) !== (cexp & cmask)) begin
            n_fail++; $display("FAIL %s_lanes: got %h, required %h", nm, data_out & cmask, cexp & cmask);
        end
        n_tests++;
        if (first_start !== acc + 2) begin
            n_fail++; $display("FAIL %s_latency: start cycle %0d, required %0d", nm, first_start, acc + 2);
        end
        n_tests++;
        if (hold_viol !== 0) begin
            n_fail++; $display("FAIL %s_hold: data changes outside start %0d, required 0", nm, hold_viol);
        end
        n_tests++;
        if (fd_count !== 0) begin
            n_fail++; $display("FAIL %s_frame_done: pulses %0d, required 0", nm, fd_count);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        n_tests++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", din_ready); end
        n_tests++;
        if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", data_out); end
        n_tests++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b, required 0", start); end
        n_tests++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        apply_reset();
        n_tests++;
        if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b, required 1", din_ready); end
    endtask

    task automatic test_single_window();
        logic [W-1:0] p0, p1, p2, p3, m, e;
        p0 = rand256(); p1 = rand256(); p2 = rand256(); p3 = rand256();
        p0[15:0] = 16'd3; p1[15:0] = 16'hFFF9; p2[15:0] = 16'd12; p3[15:0] = 16'd5;
        m = '0; m[15:0] = 16'hFFFF;
        e = '0; e[15:0] = 16'd12;
        apply_reset();
        run_window(p0, p1, p2, p3, m, e, "single_window");
    endtask

    task automatic test_all_negative();
        logic [W-1:0] m, e;
        m = '1;
`ifdef POOL1_SENDER_RELU_EN
        e = '0;
`else
        e = {16{16'hFFFF}};
`endif
        apply_reset();
        run_window({16{16'hFFFF}}, {16{16'hFFFE}}, {16{16'hFFFD}}, {16{16'hFFFC}}, m, e, "all_negative");
    endtask

    task automatic test_extremes();
        logic [W-1:0] p0, p1, p2, p3, m, e;
        p0 = rand256(); p1 = rand256(); p2 = rand256(); p3 = rand256();
        p0[255:240] = 16'h8000; p1[255:240] = 16'h8000; p2[255:240] = 16'h8000; p3[255:240] = 16'h8000;
        p0[15:0] = 16'h8000; p1[15:0] = 16'h8000; p2[15:0] = 16'h7FFF; p3[15:0] = 16'h8000;
        m = '0; m[15:0] = 16'hFFFF; m[255:240] = 16'hFFFF;
        e = '0; e[15:0] = 16'h7FFF;
`ifdef POOL1_SENDER_RELU_EN
        e[255:240] = 16'h0000;
`else
        e[255:240] = 16'h8000;
`endif
        apply_reset();
        run_window(p0, p1, p2, p3, m, e, "extremes");
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] m;
        apply_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < L; c++) img[r][c] = rand256();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < L; c++) send_beat(r, c, 0);
        for (int c = 0; c < 17; c++) send_beat(3, c, 0);
        din = img[3][17];
        din_valid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk_in);
        n_tests++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b, required 0", din_ready); end
        n_tests++;
        if (data_out !== '0) begin n_fail++; $display("FAIL midreset_data: got %h, required 0", data_out); end
        n_tests++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL midreset_start: got %b, required 0", start); end
        n_tests++;
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_frame_done: got %b, required 0", frame_done); end
        din_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        m = '0;
        run_window(rand256(), rand256(), rand256(), rand256(), m, m, "after_midreset");
    endtask

    // Streams a complete random frame and checks the pooled stream in order.
    task automatic run_frame(input int gap_max, input int fd_expected, input string nm);
        logic [W-1:0] exp_q [$];
        int           base;
        int           mism;
        int           first_bad;
        int           last_s;
        base = got_q.size();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++) img[r][c] = rand256();
        for (int pr = 0; pr < H / 2; pr++)
            for (int pc = 0; pc < L / 2; pc++) exp_q.push_back(ref_pool(pr, pc));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < L; c++) send_beat(r, c, gap_max);
        wait_starts(base + NPIX, 8000, nm);
        repeat (20) @(negedge clk_in);
        mism = 0; first_bad = -1;
        for (int i = 0; i < NPIX; i++) begin
            if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        last_s = (start_cyc_q.size() > 0) ? start_cyc_q[$] : -100;
        n_tests++;
        if (got_q.size() !== base + NPIX) begin
            n_fail++; $display("FAIL %s_start_count: got %0d, required %0d", nm, got_q.size() - base, NPIX);
        end
        n_tests++;
        if (mism !== 0) begin
            n_fail++; $display("FAIL %s_data: %0d wrong pixels (first index %0d), required 0", nm, mism, first_bad);
        end
        n_tests++;
        if (spacing_viol !== 0) begin
            n_fail++; $display("FAIL %s_spacing: %0d starts closer than %0d cycles, required 0", nm, spacing_viol, PERIOD);
        end
        n_tests++;
        if (hold_viol !== 0) begin
            n_fail++; $display("FAIL %s_hold: data changes outside start %0d, required 0", nm, hold_viol);
        end
        n_tests++;
        if (fd_count !== fd_expected) begin
            n_fail++; $display("FAIL %s_frame_done_count: got %0d, required %0d", nm, fd_count, fd_expected);
        end
        n_tests++;
        if (fd_last_cyc <= last_s || fd_last_cyc > last_s + PERIOD) begin
            n_fail++; $display("FAIL %s_frame_done_time: cycle %0d, required within (%0d,%0d]", nm, fd_last_cyc, last_s, last_s + PERIOD);
        end
        n_tests++;
        if (rdy_viol !== 0) begin
            n_fail++; $display("FAIL %s_ready_level: %0d cycles inconsistent with queue level, required 0", nm, rdy_viol);
        end
    endtask

    task automatic test_full_frame();
        apply_reset();
        run_frame(0, 1, "full_frame");
        n_tests++;
        if (rdy_low_seen == 0) begin
            n_fail++; $display("FAIL full_frame_backpressure: ready-low cycles %0d, required >0", rdy_low_seen);
        end
        n_tests++;
        if (min_spacing !== PERIOD) begin
            n_fail++; $display("FAIL full_frame_throughput: min start spacing %0d, required %0d", min_spacing, PERIOD);
        end
    endtask

    task automatic test_random_gaps();
        run_frame(3, 2, "random_gaps");
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_all_negative();
        test_extremes();
        test_reset_mid_frame();
        test_full_frame();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
